// File: rtl/servo_ramp_if.sv
// Command and position bundle between a target source (master) and servo_ramp (slave).
interface servo_ramp_if;
   logic       cmd_valid;
   logic [7:0] cmd_target;
   logic       cmd_ready;
   logic [7:0] rotation;
   logic       set_rotation;
   logic       busy;

   modport master (
      output cmd_valid,
      output cmd_target,
      input  cmd_ready,
      input  rotation,
      input  set_rotation,
      input  busy
   );

   modport slave (
      input  cmd_valid,
      input  cmd_target,
      output cmd_ready,
      output rotation,
      output set_rotation,
      output busy
   );
endinterface

// File: rtl/servo_ramp.sv
// Servo command slew limiter: moves the commanded position toward the target by at most STEP per frame.
// Optional feature macro SERVO_RAMP_LIMIT_EN clamps accepted targets to [MIN_POS, MAX_POS].
module servo_ramp #(
   parameter int unsigned FRAME_CYCLES = 1000000,
   parameter int unsigned STEP         = 4,
   parameter int unsigned INIT_POS     = 128,
   parameter int unsigned MIN_POS      = 0,
   parameter int unsigned MAX_POS      = 255
) (
   input  logic           clk,
   input  logic           rst,
   servo_ramp_if.slave    bus
);

   localparam int unsigned CW       = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);
   localparam logic [7:0] STEP_B    = 8'(STEP);
   localparam logic [7:0] INIT_B    = 8'(INIT_POS);

   if (FRAME_CYCLES < 4 || STEP < 1 || STEP > 255 || INIT_POS > 255 ||
       MIN_POS > MAX_POS || MAX_POS > 255) begin : g_cfg_error
      $error("servo_ramp: illegal parameter configuration");
   end

`ifdef SERVO_RAMP_LIMIT_EN
   localparam logic [7:0] MIN_B = 8'(MIN_POS);
   localparam logic [7:0] MAX_B = 8'(MAX_POS);

   if (INIT_POS < MIN_POS || INIT_POS > MAX_POS) begin : g_init_range_error
      $error("servo_ramp: INIT_POS outside [MIN_POS, MAX_POS]");
   end
`endif

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      IDLE   = 2'd1,
      MOVING = 2'd2,
      STROBE = 2'd3
   } state_t;

   function automatic logic [7:0] clamp_target(input logic [7:0] t);
      logic [7:0] r;
`ifdef SERVO_RAMP_LIMIT_EN
      if (t < MIN_B) begin
         r = MIN_B;
      end else if (t > MAX_B) begin
         r = MAX_B;
      end else begin
         r = t;
      end
`else
      r = t;
`endif
      return r;
   endfunction

   // Signed 9-bit difference keeps 250 -> 5 descending instead of wrapping through 255.
   function automatic logic [7:0] step_toward(input logic [7:0] pos, input logic [7:0] tgt);
      logic signed [8:0] diff;
      logic [8:0]        mag;
      logic [7:0]        r;
      diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
      mag  = diff[8] ? 9'(-diff) : 9'(diff);
      if (mag <= {1'b0, STEP_B}) begin
         r = tgt;
      end else if (diff[8]) begin
         r = pos - STEP_B;
      end else begin
         r = pos + STEP_B;
      end
      return r;
   endfunction

   state_t        state_r;
   state_t        state_s;
   logic [7:0]    rotation_r;
   logic [7:0]    rotation_s;
   logic [7:0]    target_r;
   logic [7:0]    target_s;
   logic [CW-1:0] cnt_r;
   logic          set_rotation_r;
   logic          set_rotation_s;
   logic          busy_r;
   logic          busy_s;
   logic          cmd_ready_r;
   logic          cmd_ready_s;
   logic          tick_s;
   logic          accept_s;
   logic [7:0]    cmd_clamped_s;
   logic [7:0]    eff_target_s;

   assign tick_s = (cnt_r == LAST_CNT);

   // Next-state, next-position and next-output decode.
   always_comb begin
      state_s        = state_r;
      rotation_s     = rotation_r;
      accept_s       = bus.cmd_valid && cmd_ready_r;
      cmd_clamped_s  = clamp_target(bus.cmd_target);
      eff_target_s   = accept_s ? cmd_clamped_s : target_r;
      target_s       = eff_target_s;

      case (state_r)
         LOAD: begin
            state_s = IDLE;
         end
         IDLE: begin
            if (accept_s && (cmd_clamped_s != rotation_r)) begin
               state_s = MOVING;
            end else begin
               state_s = IDLE;
            end
         end
         MOVING: begin
            // The step uses the stored target; a command on the tick cycle takes effect next frame.
            if (tick_s) begin
               rotation_s = step_toward(rotation_r, target_r);
               state_s    = STROBE;
            end else begin
               state_s    = MOVING;
            end
         end
         STROBE: begin
            if (rotation_r == eff_target_s) begin
               state_s = IDLE;
            end else begin
               state_s = MOVING;
            end
         end
         default: begin
            state_s = LOAD;
         end
      endcase

      set_rotation_s = (state_r == LOAD) || (state_r == STROBE);
      busy_s         = (state_s == MOVING) || (state_s == STROBE);
      cmd_ready_s    = (state_r != LOAD) && !accept_s;
   end

   // State, position and registered output update.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= LOAD;
         rotation_r     <= INIT_B;
         target_r       <= INIT_B;
         set_rotation_r <= 1'b0;
         busy_r         <= 1'b0;
         cmd_ready_r    <= 1'b0;
      end else begin
         state_r        <= state_s;
         rotation_r     <= rotation_s;
         target_r       <= target_s;
         set_rotation_r <= set_rotation_s;
         busy_r         <= busy_s;
         cmd_ready_r    <= cmd_ready_s;
      end
   end

   // Free-running frame counter; the last count is the frame tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (tick_s) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign bus.rotation     = rotation_r;
   assign bus.set_rotation = set_rotation_r;
   assign bus.busy         = busy_r;
   assign bus.cmd_ready    = cmd_ready_r;

endmodule

// File: tb/tb_servo_ramp.sv
// Self-checking bench for servo_ramp: directed scenarios plus random traffic against a behavioural model.
module tb_servo_ramp;
   localparam int FRAME = 10;
   localparam int STEP  = 4;
   localparam int INIT  = 128;
   localparam int MINP  = 20;
   localparam int MAXP  = 200;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   servo_ramp_if bus ();

   servo_ramp #(
      .FRAME_CYCLES(FRAME),
      .STEP(STEP),
      .INIT_POS(INIT),
      .MIN_POS(MINP),
      .MAX_POS(MAXP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int strobes_seen = 0;

   // Behavioural model: position, target, frame phase, and "move pending" / "just moved" flags.
   int m_pos, m_tgt, m_cnt;
   bit m_strobe, m_busy, m_ready;
   bit m_after_reset, m_pending, m_moved;

   function automatic int clamp(input int t);
`ifdef SERVO_RAMP_LIMIT_EN
      return (t < MINP) ? MINP : ((t > MAXP) ? MAXP : t);
`else
      return t;
`endif
   endfunction

   function automatic int approach(input int p, input int t);
      if (t > p) return (p + STEP < t) ? p + STEP : t;
      else       return (p - STEP > t) ? p - STEP : t;
   endfunction

   function automatic void model_edge();
      bit acc, tick;
      int newt;
      if (rst) begin
         m_pos = INIT; m_tgt = INIT; m_cnt = 0;
         m_strobe = 0; m_busy = 0; m_ready = 0;
         m_after_reset = 1; m_pending = 0; m_moved = 0;
      end else begin
         acc  = bus.cmd_valid && m_ready;
         newt = acc ? clamp(int'(bus.cmd_target)) : m_tgt;
         tick = (m_cnt == FRAME - 1);
         m_strobe = m_after_reset || m_moved;
         if (m_after_reset) begin
            m_pending = 0; m_moved = 0;
         end else if (m_pending && tick) begin
            m_pos = approach(m_pos, m_tgt);
            m_pending = 0; m_moved = 1;
         end else if (m_moved) begin
            m_moved = 0;
            m_pending = (m_pos != newt);
         end else if (!m_pending) begin
            m_pending = acc && (newt != m_pos);
         end
         m_ready = !m_after_reset && !acc;
         m_after_reset = 0;
         m_tgt = newt;
         m_cnt = (m_cnt + 1) % FRAME;
         m_busy = m_pending || m_moved;
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("rotation", 32'(bus.rotation), 32'(m_pos));
      check("set_rotation", 32'(bus.set_rotation), 32'(m_strobe));
      check("busy", 32'(bus.busy), 32'(m_busy));
      check("cmd_ready", 32'(bus.cmd_ready), 32'(m_ready));
      if (bus.set_rotation === 1'b1) strobes_seen++;
   endtask

   task automatic send(input int t);
      bit acc = 1'b0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_target = 8'(t);
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = m_ready;
         step();
      end
      bus.cmd_valid = 1'b0;
      check("accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic settle(input int limit);
      int n = 0;
      while (m_busy && n < limit) begin
         step();
         n++;
      end
      check("settle_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic run_until_pos(input int p, input int limit);
      int n = 0;
      while (m_pos != p && n < limit) begin
         step();
         n++;
      end
      check("reach_pos", 32'(bus.rotation), 32'(p));
   endtask

   initial begin
      rst = 1'b1;
      bus.cmd_valid  = 1'b0;
      bus.cmd_target = 8'd0;
      repeat (3) step();
      check("rst_rotation", 32'(bus.rotation), 32'd128);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ready", 32'(bus.cmd_ready), 32'd0);

      // Release: one LOAD strobe, then ready the cycle after.
      rst = 1'b0;
      step();
      check("load_strobe", 32'(bus.set_rotation), 32'd1);
      check("load_ready", 32'(bus.cmd_ready), 32'd0);
      step();
      check("load_strobe_end", 32'(bus.set_rotation), 32'd0);
      check("ready_rise", 32'(bus.cmd_ready), 32'd1);
      repeat (3) step();

      // 128 -> 140 in three full steps.
      strobes_seen = 0;
      send(140);
      run_until_pos(132, 40);
      run_until_pos(136, 40);
      settle(100);
      check("ramp140_pos", 32'(bus.rotation), 32'd140);
      check("ramp140_strobes", 32'(strobes_seen), 32'd3);
      repeat (2) step();

      // Back to 128, then a partial step to 130, then a same-position command.
      send(128);
      settle(100);
      strobes_seen = 0;
      send(130);
      settle(100);
      check("partial_pos", 32'(bus.rotation), 32'd130);
      check("partial_strobes", 32'(strobes_seen), 32'd1);
      repeat (2) step();
      strobes_seen = 0;
      send(130);
      repeat (25) step();
      check("same_busy", 32'(bus.busy), 32'd0);
      check("same_strobes", 32'(strobes_seen), 32'd0);

      // Reversal mid-move.
      send(200);
      run_until_pos(138, 40);
      send(100);
      settle(400);
      check("reverse_pos", 32'(bus.rotation), 32'd100);

      // Large ascent then descent without wrap (clamped when limits are enabled).
      send(250);
      settle(1000);
`ifdef SERVO_RAMP_LIMIT_EN
      check("high_pos", 32'(bus.rotation), 32'd200);
`else
      check("high_pos", 32'(bus.rotation), 32'd250);
`endif
      send(5);
      settle(1000);
`ifdef SERVO_RAMP_LIMIT_EN
      check("low_pos", 32'(bus.rotation), 32'd20);
`else
      check("low_pos", 32'(bus.rotation), 32'd5);
`endif
      send(0);
      settle(200);
`ifdef SERVO_RAMP_LIMIT_EN
      check("zero_pos", 32'(bus.rotation), 32'd20);
`else
      check("zero_pos", 32'(bus.rotation), 32'd0);
`endif

      // Reset mid-move at 136.
      send(128);
      settle(600);
      send(200);
      run_until_pos(136, 40);
      rst = 1'b1;
      step();
      check("midrst_pos", 32'(bus.rotation), 32'd128);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      strobes_seen = 0;
      repeat (40) step();
      check("midrst_strobes", 32'(strobes_seen), 32'd1);
      check("midrst_hold", 32'(bus.rotation), 32'd128);

      // Random traffic, with targets often near the current position.
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         bus.cmd_valid = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 2) == 0)
            bus.cmd_target = 8'((m_pos + int'($urandom_range(0, 12)) - 6 + 256) % 256);
         else
            bus.cmd_target = 8'($urandom_range(0, 255));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
